fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit. Holds the program counter and issues one word-aligned request at a time to instruction memory over a valid/ready handshake. It registers each returned word, together with its PC and PC+4, in a one-deep output slot that the control unit decodes. Branch/jump redirects flush the slot and discard any in-flight response.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, one-deep decode slot.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and raise fetch_misaligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        fetch_misaligned
);
    typedef enum logic [1:0] {S_RESET, S_REQ, S_WAIT, S_HALT} state_t;

    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;
    logic        valid_d;
    logic [31:0] instr_d, ipc_d, ip4_d;
    logic        slot_free, consume, load, redirect_bad;

    assign imem_req_addr    = pc_q;
    assign slot_free        = !instr_valid || !stall;
    assign consume          = instr_valid && !stall;
    assign imem_req_valid   = !rst && (state_q == S_REQ) && slot_free && !redirect_en;
    assign fetch_misaligned = mis_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_bad = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_bad = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        kill_d  = kill_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        valid_d = instr_valid;
        instr_d = instruction;
        ipc_d   = instr_pc;
        ip4_d   = instr_pc_plus4;
        load    = 1'b0;

        unique case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ:   if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    load    = !kill_q && !redirect_en;
                end
            end
            default: ;
        endcase

        // A load wins over a same-cycle consume; the new word replaces the old one.
        if (load) begin
            valid_d = 1'b1;
            instr_d = imem_rsp_data;
            ipc_d   = pc_q;
            ip4_d   = pc_q + 32'd4;
            pc_d    = pc_q + 32'd4;
        end else if (consume) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (redirect_en && (state_q != S_HALT)) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (redirect_bad) begin
                mis_d   = 1'b1;
                kill_d  = 1'b0;
                state_d = S_HALT;
            end else begin
                pc_d = redirect_pc & PC_ALIGN_MASK;
                // The in-flight response has not arrived yet: remember to drop it.
                if ((state_q == S_WAIT) && !imem_rsp_valid) kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q        <= S_RESET;
            kill_q         <= 1'b0;
            pc_q           <= RESET_PC_ALIGNED;
            mis_q          <= 1'b0;
            instr_valid    <= 1'b0;
            instruction    <= NOP_INSTR;
            instr_pc       <= 32'h0;
            instr_pc_plus4 <= 32'h0;
        end else begin
            state_q        <= state_d;
            kill_q         <= kill_d;
            pc_q           <= pc_d;
            mis_q          <= mis_d;
            instr_valid    <= valid_d;
            instruction    <= instr_d;
            instr_pc       <= ipc_d;
            instr_pc_plus4 <= ip4_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level memory plus a reference of the
// fetch stream (expected PC, slot contents, request timing) checked every cycle.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          N_CYCLES = 2000;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction, instr_pc, instr_pc_plus4;
    logic        fetch_misaligned;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .fetch_misaligned(fetch_misaligned)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory image; address 0 holds 32'h00A00093.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
    endfunction

    // Memory model state: one pending response with a countdown.
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    // Reference fetch-stream state.
    bit          m_boot, m_busy, m_doomed, m_halt, m_mis, m_valid;
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;

    task automatic model_reset();
        m_boot = 1'b1; m_busy = 1'b0; m_doomed = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
        m_pc = RESET_PC & 32'hFFFF_FFFC;
        m_valid = 1'b0; m_instr = NOP; m_ipc = '0; m_ip4 = '0;
    endtask

    function automatic bit exp_req_valid();
        return !rst && !m_boot && !m_halt && !m_busy && (!m_valid || !stall) && !redirect_en;
    endfunction

    task automatic model_step();
        bit consume, rsp_here, accept, load;
        consume  = m_valid && !stall;
        rsp_here = m_busy && imem_rsp_valid;
        accept   = exp_req_valid() && imem_req_ready;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_halt) begin
            // Fetch is frozen until reset.
        end else if (redirect_en) begin
            m_valid = 1'b0;
            m_instr = NOP;
            if (TRAP && (redirect_pc[1:0] != 2'b00)) begin
                m_halt = 1'b1; m_mis = 1'b1; m_busy = 1'b0; m_doomed = 1'b0;
            end else begin
                m_pc = {redirect_pc[31:2], 2'b00};
                if (rsp_here) begin
                    m_busy = 1'b0; m_doomed = 1'b0;
                end else if (m_busy) begin
                    m_doomed = 1'b1;
                end
            end
        end else begin
            load = rsp_here && !m_doomed;
            if (rsp_here) begin
                m_busy = 1'b0; m_doomed = 1'b0;
            end
            if (load) begin
                m_valid = 1'b1; m_instr = mem_word(m_pc); m_ipc = m_pc; m_ip4 = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
            end else if (consume) begin
                m_valid = 1'b0; m_instr = NOP;
            end
        end
        if (accept) m_busy = 1'b1;
        m_boot = 1'b0;
    endtask

    initial begin
        logic [31:0] rt;
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        repeat (2) @(posedge clk);
        model_reset();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                end
            end

            rst = (cyc == 320) || (cyc % 700 == 699);

            if (cyc < 40) stall = 1'b0;
            else if (cyc >= 100 && cyc < 105) stall = 1'b1;
            else stall = ($urandom_range(0, 3) == 0);

            // Fixed redirects: wrap-around, aligned target, misaligned target.
            redirect_en = 1'b0;
            if (cyc == 60) begin
                redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8;
            end else if (cyc == 150) begin
                redirect_en = 1'b1; redirect_pc = 32'h0000_0100;
            end else if (cyc == 250) begin
                redirect_en = 1'b1; redirect_pc = 32'h0000_0102;
            end else if (cyc >= 40 && $urandom_range(0, 24) == 0) begin
                rt = $urandom;
                if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
                if ($urandom_range(0, 5) == 0) rt[31:4] = 28'hFFF_FFFF;
                redirect_en = 1'b1; redirect_pc = rt;
            end

            imem_req_ready = (mem_cnt == 0) && (cyc < 40 || $urandom_range(0, 3) != 0);

            @(negedge clk);
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_valid()});
            check("req_addr", imem_req_addr, m_pc);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            check("instruction", instruction, m_instr);
            check("instr_pc", instr_pc, m_ipc);
            check("instr_pc_plus4", instr_pc_plus4, m_ip4);
            check("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_mis});

            if (imem_req_valid && imem_req_ready) begin
                mem_addr = imem_req_addr;
                mem_cnt  = (cyc < 40) ? 1 : $urandom_range(1, 3);
            end
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
